// File: rtl/stack_arbiter_if.sv
// Requester, response and stack-side signals of the two-port stack arbiter.
interface stack_arbiter_if #(
  parameter int unsigned DW = 4
);
  logic          req0_valid;
  logic          req0_op;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  logic          req1_valid;
  logic          req1_op;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  logic          rsp0_valid;
  logic          rsp1_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_data_in;
  logic [DW-1:0] stk_data_out;
  logic          stk_full;
  logic          stk_empty;

  modport slave (
    input  req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data,
           stk_data_out, stk_full, stk_empty,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
           busy, stk_push, stk_pop, stk_data_in
  );

  modport master (
    output req0_valid, req0_op, req0_data, req1_valid, req1_op, req1_data,
           stk_data_out, stk_full, stk_empty,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_err,
           busy, stk_push, stk_pop, stk_data_in
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter serialising push/pop operations from two requesters
// onto a single stack, one operation every three cycles.
module stack_arbiter #(
  parameter int unsigned DW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  stack_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          ptr;
  logic          owner;
  logic          op_q;
  logic          err_q;
  logic [DW-1:0] operand_q;

  logic          gnt0;
  logic          gnt1;
  logic          grant;
  logic          win;
  logic          win_op;
  logic          win_err;
  logic [DW-1:0] win_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant decode; ready is held low during reset even though state reads IDLE
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && rst_n) begin
      gnt1 = bus.req1_valid & (~bus.req0_valid | ptr);
      gnt0 = bus.req0_valid & ~gnt1;
    end
  end

  assign grant          = gnt0 | gnt1;
  assign win            = gnt1;
  assign win_op         = win ? bus.req1_op : bus.req0_op;
  assign win_data       = win ? bus.req1_data : bus.req0_data;
  assign win_err        = win_op ? bus.stk_empty : bus.stk_full;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.busy       = (state != IDLE);

  // Latch the granted operation, issue stack strobes, build the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr             <= 1'b0;
      owner           <= 1'b0;
      op_q            <= 1'b0;
      err_q           <= 1'b0;
      operand_q       <= '0;
      bus.stk_push    <= 1'b0;
      bus.stk_pop     <= 1'b0;
      bus.stk_data_in <= '0;
      bus.rsp0_valid  <= 1'b0;
      bus.rsp1_valid  <= 1'b0;
      bus.rsp_data    <= '0;
      bus.rsp_err     <= 1'b0;
    end else begin
      bus.stk_push <= 1'b0;
      bus.stk_pop  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            ptr             <= ~win;
            owner           <= win;
            op_q            <= win_op;
            err_q           <= win_err;
            operand_q       <= win_data;
            bus.stk_push    <= ~win_op & ~win_err;
            bus.stk_pop     <= win_op & ~win_err;
            bus.stk_data_in <= win_data;
          end
        end
        EXEC: begin
          // Pop data is sampled on the same edge the stack consumes the pop
          bus.rsp0_valid <= ~owner;
          bus.rsp1_valid <= owner;
          bus.rsp_err    <= err_q;
          bus.rsp_data   <= err_q ? '0 : (op_q ? bus.stk_data_out : operand_q);
        end
        RESP: begin
          bus.rsp0_valid <= 1'b0;
          bus.rsp1_valid <= 1'b0;
          bus.rsp_err    <= 1'b0;
          bus.rsp_data   <= '0;
        end
        default: begin
          bus.rsp0_valid <= 1'b0;
          bus.rsp1_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Self-checking bench for stack_arbiter: directed scenarios plus a random run
// against a transaction-level model of arbitration and a small behavioural stack.
module tb_stack_arbiter;

  localparam int unsigned DW    = 4;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic ptr_m;

  stack_arbiter_if #(.DW(DW)) bus ();

  stack_arbiter #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural stack, cleared together with the arbiter
  logic [DW-1:0] mem [0:DEPTH-1];
  int            cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0;
    end else if (bus.stk_push && cnt < DEPTH) begin
      mem[2'(cnt)] <= bus.stk_data_in;
      cnt          <= cnt + 1;
    end else if (bus.stk_pop && cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  assign bus.stk_data_out = (cnt > 0) ? mem[2'(cnt - 1)] : '0;
  assign bus.stk_full     = (cnt == DEPTH);
  assign bus.stk_empty    = (cnt == 0);

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v0, input logic o0, input logic [DW-1:0] d0,
                         input logic v1, input logic o1, input logic [DW-1:0] d1);
    bus.req0_valid = v0; bus.req0_op = o0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_op = o1; bus.req1_data = d1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_rdy0"}, bus.req0_ready, 1'b0);
    chk1({tag, "_rdy1"}, bus.req1_ready, 1'b0);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_push"}, bus.stk_push, 1'b0);
    chk1({tag, "_pop"},  bus.stk_pop, 1'b0);
    chk1({tag, "_rsp0"}, bus.rsp0_valid, 1'b0);
    chk1({tag, "_rsp1"}, bus.rsp1_valid, 1'b0);
    chk1({tag, "_err"},  bus.rsp_err, 1'b0);
    chkd({tag, "_rdat"}, bus.rsp_data, '0);
    chkd({tag, "_din"},  bus.stk_data_in, '0);
  endtask

  // Reset with both requesters asserting; every output must stay low
  task automatic do_reset();
    rst_n = 1'b0;
    set_req(1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 4'h8);
    #1;
    chk_all_zero("rst");
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("rst_hold");
    rst_n = 1'b1;
    ptr_m = 1'b0;
    set_req(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  // One arbitration slot, called at a falling edge while the arbiter is idle.
  // Inputs stay held through EXEC and RESP, so held VALID must see READY=0.
  task automatic run_op(input logic v0, input logic o0, input logic [DW-1:0] d0,
                        input logic v1, input logic o1, input logic [DW-1:0] d1);
    logic          win;
    logic          op;
    logic          err;
    logic [DW-1:0] d;
    logic [DW-1:0] top;
    logic [DW-1:0] rexp;
    set_req(v0, o0, d0, v1, o1, d1);
    #1;
    if (!v0 && !v1) begin
      chk1("idle_rdy0", bus.req0_ready, 1'b0);
      chk1("idle_rdy1", bus.req1_ready, 1'b0);
      @(negedge clk);
      chk1("idle_busy", bus.busy, 1'b0);
      chk1("idle_strobe", bus.stk_push | bus.stk_pop, 1'b0);
      return;
    end
    win   = (v0 && v1) ? ptr_m : v1;
    ptr_m = ~win;
    op    = win ? o1 : o0;
    d     = win ? d1 : d0;
    err   = op ? (cnt == 0) : (cnt == DEPTH);
    top   = (cnt > 0) ? mem[2'(cnt - 1)] : '0;
    rexp  = err ? '0 : (op ? top : d);
    chk1("grant_rdy0", bus.req0_ready, ~win);
    chk1("grant_rdy1", bus.req1_ready, win);
    chk1("grant_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk1("exec_push", bus.stk_push, ~op & ~err);
    chk1("exec_pop", bus.stk_pop, op & ~err);
    if (!op && !err) chkd("exec_din", bus.stk_data_in, d);
    chk1("exec_busy", bus.busy, 1'b1);
    chk1("exec_rdy", bus.req0_ready | bus.req1_ready, 1'b0);
    chk1("exec_rsp", bus.rsp0_valid | bus.rsp1_valid, 1'b0);
    chkd("exec_rdat", bus.rsp_data, '0);
    chk1("exec_err", bus.rsp_err, 1'b0);
    @(negedge clk);
    chk1("resp_v0", bus.rsp0_valid, ~win);
    chk1("resp_v1", bus.rsp1_valid, win);
    chk1("resp_err", bus.rsp_err, err);
    chkd("resp_data", bus.rsp_data, rexp);
    chk1("resp_strobe", bus.stk_push | bus.stk_pop, 1'b0);
    chk1("resp_busy", bus.busy, 1'b1);
    chk1("resp_rdy", bus.req0_ready | bus.req1_ready, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rv;
    rst_n = 1'b0;
    ptr_m = 1'b0;
    set_req(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    // Single push from requester 0 on an empty stack
    do_reset();
    run_op(1'b1, 1'b0, 4'h5, 1'b0, 1'b0, 4'h0);

    // Both requesters pushing back to back: grants alternate 0,1,0,1
    do_reset();
    run_op(1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 4'h2);
    run_op(1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 4'h4);
    run_op(1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 4'h6);
    run_op(1'b1, 1'b0, 4'h7, 1'b1, 1'b0, 4'h8);

    // Lone requester 1 wins against pointer 0, then both valid goes to 0
    do_reset();
    run_op(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'h3);
    run_op(1'b1, 1'b0, 4'h9, 1'b1, 1'b0, 4'hE);
    // Pops return 9 then 3, third pop on empty is rejected
    run_op(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0);
    run_op(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0);
    run_op(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'h0);

    // Fill the stack, then a push on full is rejected
    for (int i = 0; i < DEPTH; i++) run_op(1'b1, 1'b0, 4'(i + 1), 1'b0, 1'b0, '0);
    run_op(1'b1, 1'b0, 4'hA, 1'b0, 1'b0, '0);
    run_op(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    // Reset pulse in the middle of a pop's EXEC cycle
    set_req(1'b1, 1'b1, '0, 1'b0, 1'b0, '0);
    #1;
    chk1("abort_rdy0", bus.req0_ready, 1'b1);
    @(negedge clk);
    chk1("abort_pop_before", bus.stk_pop, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("abort_pop_drop", bus.stk_pop, 1'b0);
    chk1("abort_busy", bus.busy, 1'b0);
    @(negedge clk);
    chk1("abort_no_rsp", bus.rsp0_valid | bus.rsp1_valid, 1'b0);
    chk1("abort_no_strobe", bus.stk_push | bus.stk_pop, 1'b0);
    rst_n = 1'b1;
    ptr_m = 1'b0;
    run_op(1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 4'h2);

    // Randomised traffic against the model
    for (int i = 0; i < 1000; i++) begin
      rv = $urandom;
      run_op(rv[0] | rv[12], rv[1], rv[5:2], rv[6] | rv[13], rv[7], rv[11:8]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter DW, default 4, stack data width in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset; asynchronous assert, active-low.
REQ-004 REQ0_VALID / REQ1_VALID  input  1 each  requester n has an operation pending.
REQ-005 REQ0_OP / REQ1_OP  input  1 each  0 = push, 1 = pop.
REQ-006 REQ0_DATA / REQ1_DATA  input  DW each  push operand.
REQ-007 REQ0_READY / REQ1_READY  output  1 each  combinational accept; handshake when VALID and READY are both high.
REQ-008 RSP0_VALID / RSP1_VALID  output  1 each  one-cycle response pulse to requester n.
REQ-009 RSP_DATA  output  DW  popped value for a pop, echoed operand for a push; shared by both requesters.
REQ-010 RSP_ERR  output  1  operation rejected (push when full, pop when empty).
REQ-011 BUSY  output  1  high whenever the state is not IDLE.
REQ-012 STK_PUSH / STK_POP  output  1 each  registered one-cycle strobes to the stack.
REQ-013 STK_DATA_IN  output  DW  registered push operand to the stack.
REQ-014 STK_DATA_OUT  input  DW  current top of stack, combinational from the stack.
REQ-015 STK_FULL / STK_EMPTY  input  1 each  stack status flags.

Function
REQ-016 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE, fixed at one accepted operation per 3 cycles.
REQ-017 IDLE: if any REQn_VALID is high, SHALL assert READY for exactly one winner in the same cycle and move to EXEC; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin with a 1-bit pointer; with both valid, the requester named by the pointer wins; with one valid, that requester wins regardless of the pointer.
REQ-019 On each grant to requester n, the pointer SHALL become 1-n.
REQ-020 READY SHALL be 0 in EXEC and RESP, and a losing requester SHALL see READY=0.
REQ-021 At grant, the FSM SHALL latch owner, op and operand; it SHALL latch err = (push and STK_FULL) or (pop and STK_EMPTY).
REQ-022 EXEC with err=0 SHALL assert exactly one of STK_PUSH or STK_POP for that single cycle, with STK_DATA_IN equal to the latched operand.
REQ-023 EXEC with err=1 SHALL assert no stack strobe.
REQ-024 EXEC pop with err=0 SHALL capture STK_DATA_OUT into the response register on the same edge that the stack consumes the pop.
REQ-025 RESP SHALL pulse RSPowner_VALID for one cycle, with RSP_ERR equal to err.
REQ-026 RESP SHALL drive RSP_DATA as the captured value (pop), the operand (push), or 0 (err=1).
REQ-027 RSP_DATA and RSP_ERR SHALL be 0 in every cycle in which no RSPn_VALID is high.
REQ-028 Requesters SHALL NOT be required to hold VALID after the handshake, and VALID held high SHALL be treated as a new request in the next IDLE.
REQ-029 STK_PUSH and STK_POP SHALL never be high simultaneously, and neither SHALL be high outside EXEC.
REQ-030 The arbiter SHALL be the sole driver of the stack, so FULL and EMPTY sampled in IDLE are authoritative.

Reset
REQ-031 While RST_N=0, state SHALL be IDLE and pointer SHALL be 0.
REQ-032 While RST_N=0, every output SHALL be 0, including READY, RSP*, BUSY, STK_PUSH, STK_POP and STK_DATA_IN.
REQ-033 Reset asserted in EXEC or RESP SHALL abort immediately: strobes and response are dropped, with no further stack strobe after release.
REQ-034 After RST_N rises, the first grant SHALL be evaluated on the first rising edge.

Verification (DW=4)
REQ-035 Reset, then REQ0 push 0x5 with stack empty -> READY0=1 in cycle 0; STK_PUSH=1 with STK_DATA_IN=0x5 in cycle 1; RSP0_VALID=1, RSP_DATA=0x5, RSP_ERR=0 in cycle 2; BUSY high in cycles 1-2.
REQ-036 Both VALID continuously, all pushes, after reset -> grant order 0,1,0,1; RSP pulses every 3 cycles alternating RSP0_VALID/RSP1_VALID.
REQ-037 Stack holds 0x3, 0x9 (top 0x9); REQ1 pop twice -> RSP_DATA 0x9 then 0x3 with RSP_ERR=0; third pop (EMPTY=1) -> RSP1_VALID=1, RSP_ERR=1, RSP_DATA=0, and no STK_POP.
REQ-038 STK_FULL=1 and REQ0 push 0xA -> no STK_PUSH; RSP0_VALID=1 with RSP_ERR=1 two cycles after grant.
REQ-039 RST_N pulsed low during EXEC of a pop -> STK_POP drops asynchronously; no RSP pulse; pointer=0; next grant goes to REQ0 when both are valid.
REQ-040 REQ1 valid alone with pointer=0 -> REQ1 granted; pointer becomes 0; STK_PUSH and STK_POP are never both high across a randomized 1000-operation run.
